// File: rtl/clip_seq_pkg.sv
//------------------------------------------------------------------------------
// Module      : clip_seq_pkg
// Description : Shared types and constants for the clip sequencer. It holds
//               the clip-ID names, the clip address range struct, the flash
//               address table and the sequencer state encoding.
// Options     : none (CLIP_SEQ_STATS_EN is consumed by clip_sequencer)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package clip_seq_pkg;

    // Spoken clip identifiers as issued by the calculator front end
    localparam int CLIP_ZERO   = 0;
    localparam int CLIP_ONE    = 1;
    localparam int CLIP_TWO    = 2;
    localparam int CLIP_THREE  = 3;
    localparam int CLIP_FOUR   = 4;
    localparam int CLIP_FIVE   = 5;
    localparam int CLIP_SIX    = 6;
    localparam int CLIP_SEVEN  = 7;
    localparam int CLIP_EIGHT  = 8;
    localparam int CLIP_NINE   = 9;
    localparam int CLIP_PLUS   = 10;
    localparam int CLIP_MINUS  = 11;
    localparam int CLIP_TIMES  = 12;
    localparam int CLIP_DIVIDE = 13;
    localparam int CLIP_EQUALS = 14;
    localparam int CLIP_POINT  = 15;

    // Number of IDs that own a real recording; every other ID is silent
    localparam int NUM_CLIPS = 16;

    // One-sample silent clip used for unknown or unused IDs
    localparam logic [23:0] SILENCE_ADDR = 24'h3FF000;

    // Byte range of one clip in flash (first and last sample address)
    typedef struct packed {
        logic [23:0] start_addr;
        logic [23:0] end_addr;
    } clip_range_t;

    // Flash layout, entry n is {start, end} of clip ID n
    localparam logic [47:0] CLIP_TABLE [NUM_CLIPS] = '{
        48'h010000_016FFF,
        48'h018000_01D3FF,
        48'h020000_025FFF,
        48'h028000_02E7FF,
        48'h030000_0363FF,
        48'h038000_03DFFF,
        48'h040000_046BFF,
        48'h048000_04D7FF,
        48'h050000_0563FF,
        48'h058000_05DFFF,
        48'h060000_064FFF,
        48'h068000_06CBFF,
        48'h070000_075FFF,
        48'h078000_07D3FF,
        48'h080000_0867FF,
        48'h088000_08BFFF
    };

    // Sequencer state encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/clip_addr_rom.sv
//------------------------------------------------------------------------------
// Module      : clip_addr_rom
// Description : Combinational clip-ID to flash address range lookup. IDs
//               without a recording return the silent one-sample clip.
// Options     : none
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clip_addr_rom
    import clip_seq_pkg::*;
#(
    parameter int ID_W = 5
) (
    input  logic [ID_W-1:0] id_i,
    output clip_range_t     range_o
);

    localparam int IDX_W = $clog2(NUM_CLIPS);

    logic [IDX_W-1:0] w_idx;

    // Table lookup, falling back to silence outside the recorded range
    always_comb begin
        w_idx   = IDX_W'(id_i);
        range_o = '{start_addr: SILENCE_ADDR, end_addr: SILENCE_ADDR};
        if (32'(id_i) < NUM_CLIPS) begin
            range_o = clip_range_t'(CLIP_TABLE[w_idx]);
        end
    end

endmodule

`default_nettype wire

// File: rtl/clip_sequencer.sv
//------------------------------------------------------------------------------
// Module      : clip_sequencer
// Description : Queues spoken clip IDs and plays them back-to-back through
//               the audio playback controller, with a silent gap between
//               clips.
// Options     : CLIP_SEQ_STATS_EN adds clips_played_o and max_depth_o
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module clip_sequencer
    import clip_seq_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ID_W       = 5,
    parameter int GAP_CYCLES = 2_500_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [ID_W-1:0]          push_id_i,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     overflow_o,
    output logic                     busy_o,
    output logic                     play_start_o,
    input  logic                     play_finish_i,
    output logic [23:0]              start_address_o,
    output logic [23:0]              end_address_o
`ifdef CLIP_SEQ_STATS_EN
    ,
    output logic [15:0]              clips_played_o,
    output logic [$clog2(DEPTH):0]   max_depth_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    // The counter runs GAP_CYCLES-1 down to 0, so GAP lasts GAP_CYCLES cycles
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    logic [ID_W-1:0]  fifo_mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [GAP_W-1:0] gap_cnt_d;
    logic [23:0]      start_addr_q;
    logic [23:0]      end_addr_q;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_drop;
    logic             w_load;
    clip_range_t      w_head_range;

    assign w_full  = (count_q == CNT_W'(DEPTH));
    assign w_empty = (count_q == '0);

    // A flush wins over both a coincident push and a coincident pop
    assign w_pop     = w_load && !flush_i;
    assign w_push_ok = push_i && !flush_i && (!w_full || w_pop);
    assign w_drop    = push_i && !flush_i && w_full && !w_pop;

    // FIFO storage; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            fifo_mem_q[wr_ptr_q] <= push_id_i;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky record of any dropped push
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (w_drop) begin
            overflow_q <= 1'b1;
        end
    end

    clip_addr_rom #(
        .ID_W    (ID_W)
    ) u_rom (
        .id_i    (fifo_mem_q[rd_ptr_q]),
        .range_o (w_head_range)
    );

    // Sequencer state and gap counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state logic; a LOAD that finds the FIFO flushed backs out to IDLE
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        w_load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!w_empty) begin
                    w_load  = 1'b1;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (!play_finish_i) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (play_finish_i) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = GAP_LOAD;
                        state_d   = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clip addresses, captured at LOAD and held until the next LOAD
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_addr_q <= '0;
            end_addr_q   <= '0;
        end else if (w_load) begin
            start_addr_q <= w_head_range.start_addr;
            end_addr_q   <= w_head_range.end_addr;
        end
    end

    assign full_o          = w_full;
    assign empty_o         = w_empty;
    assign overflow_o      = overflow_q;
    assign busy_o          = (state_q != ST_IDLE);
    // Decoded from state so a reset drops it without waiting for a clock
    assign play_start_o    = (state_q == ST_START);
    assign start_address_o = start_addr_q;
    assign end_address_o   = end_addr_q;

`ifdef CLIP_SEQ_STATS_EN
    logic [15:0]      clips_played_q;
    logic [CNT_W-1:0] max_depth_q;

    // Completed-clip counter (saturating) and FIFO high-water mark
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clips_played_q <= '0;
            max_depth_q    <= '0;
        end else begin
            if ((state_q == ST_PLAY) && play_finish_i && (clips_played_q != 16'hFFFF)) begin
                clips_played_q <= clips_played_q + 16'd1;
            end
            if (count_q > max_depth_q) begin
                max_depth_q <= count_q;
            end
        end
    end

    assign clips_played_o = clips_played_q;
    assign max_depth_o    = max_depth_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clip_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_clip_sequencer
// Description : Self-checking bench for clip_sequencer. The bench acts as the
//               playback controller and keeps a queue model of the clip IDs
//               expected to play.
// Options     : CLIP_SEQ_STATS_EN also checks the statistics outputs
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_clip_sequencer;

    localparam int DEPTH = 8;
    localparam int ID_W  = 5;
    localparam int GAP   = 10;
    localparam int CNT_W = 4;
    // From finish rising in PLAY: GAP cycles of gap, one IDLE, one LOAD,
    // then START is visible at the following sample point.
    localparam int NEXT_START = GAP + 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            push;
    logic [ID_W-1:0] push_id;
    logic            flush;
    logic            full;
    logic            empty;
    logic            overflow;
    logic            busy;
    logic            play_start;
    logic            play_finish;
    logic [23:0]     start_address;
    logic [23:0]     end_address;
`ifdef CLIP_SEQ_STATS_EN
    logic [15:0]      clips_played;
    logic [CNT_W-1:0] max_depth;
`endif

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int exp_played = 0;
    bit exp_ovf    = 1'b0;

    always #5 clk = ~clk;

    clip_sequencer #(
        .DEPTH           (DEPTH),
        .ID_W            (ID_W),
        .GAP_CYCLES      (GAP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .push_i          (push),
        .push_id_i       (push_id),
        .flush_i         (flush),
        .full_o          (full),
        .empty_o         (empty),
        .overflow_o      (overflow),
        .busy_o          (busy),
        .play_start_o    (play_start),
        .play_finish_i   (play_finish),
        .start_address_o (start_address),
        .end_address_o   (end_address)
`ifdef CLIP_SEQ_STATS_EN
        ,
        .clips_played_o  (clips_played),
        .max_depth_o     (max_depth)
`endif
    );

    // Expected flash range {start, end} for a clip ID
    function automatic logic [47:0] clip_range(input int id);
        case (id)
            0:       return 48'h010000_016FFF;
            1:       return 48'h018000_01D3FF;
            2:       return 48'h020000_025FFF;
            3:       return 48'h028000_02E7FF;
            4:       return 48'h030000_0363FF;
            5:       return 48'h038000_03DFFF;
            6:       return 48'h040000_046BFF;
            7:       return 48'h048000_04D7FF;
            8:       return 48'h050000_0563FF;
            9:       return 48'h058000_05DFFF;
            10:      return 48'h060000_064FFF;
            11:      return 48'h068000_06CBFF;
            12:      return 48'h070000_075FFF;
            13:      return 48'h078000_07D3FF;
            14:      return 48'h080000_0867FF;
            15:      return 48'h088000_08BFFF;
            default: return 48'h3FF000_3FF000;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push one ID while no pop can coincide; the model applies the full rule
    task automatic push_one(input int id);
        push    = 1'b1;
        push_id = ID_W'(id);
        if (exp_q.size() < DEPTH) exp_q.push_back(id);
        else exp_ovf = 1'b1;
        tick();
        push = 1'b0;
    endtask

    // Wait for the next play_start, check gap timing and addresses, then act
    // as the controller: keep finish high 2 cycles and drop it. Optionally
    // push push_val on the sample where k == push_at (the LOAD cycle).
    task automatic begin_clip(input int exp_gap, input int push_at, input int push_val);
        int  k    = 0;
        bit  seen = 1'b0;
        int  id;
        while (k < 60 && !seen) begin
            if (play_start === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (k == push_at) begin
                    chk("full_at_load", full, 1);
                    push    = 1'b1;
                    push_id = ID_W'(push_val);
                    exp_q.push_back(push_val);
                end
                tick();
                push = 1'b0;
                k++;
            end
        end
        chk("start_seen", seen, 1);
        if (seen) begin
            if (exp_gap >= 0) chk("start_spacing", k, exp_gap);
            chk("model_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                id = exp_q.pop_front();
                chk("clip_addr", {start_address, end_address}, clip_range(id));
            end
            repeat (2) begin
                tick();
                chk("start_hold", play_start, 1);
            end
            play_finish = 1'b0;
            tick();
            chk("start_drop", play_start, 0);
        end
    endtask

    task automatic end_clip(input int low_cycles);
        repeat (low_cycles) tick();
        play_finish = 1'b1;
        exp_played++;
    endtask

    // From finish rising with nothing queued: busy lasts exactly the gap
    task automatic wait_idle();
        int n      = 0;
        int starts = 0;
        bit done   = 1'b0;
        while (n < 100 && !done) begin
            tick();
            if (play_start === 1'b1) starts++;
            if (busy === 1'b1) n++;
            else done = 1'b1;
        end
        chk("gap_length", n, GAP);
        chk("no_start_in_gap", starts, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int starts;
        bit seen;
        reset       = 1'b1;
        push        = 1'b0;
        push_id     = '0;
        flush       = 1'b0;
        play_finish = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_busy", busy, 0);
        chk("rst_play_start", play_start, 0);
        chk("rst_addr", {start_address, end_address}, 48'h0);
`ifdef CLIP_SEQ_STATS_EN
        chk("rst_clips_played", clips_played, 0);
        chk("rst_max_depth", max_depth, 0);
`endif

        // Single clip: 3-cycle latency, then gap and back to idle
        push    = 1'b1;
        push_id = ID_W'(3);
        exp_q.push_back(3);
        begin_clip(3, -1, 0);
        repeat (100) tick();
        chk("busy_in_play", busy, 1);
        play_finish = 1'b1;
        exp_played++;
        wait_idle();
`ifdef CLIP_SEQ_STATS_EN
        chk("clips_played_1", clips_played, 16'(exp_played));
`endif

        // Three back-to-back pushes play in order
        push_one(1);
        push_one(2);
        push_one(7);
        begin_clip(-1, -1, 0);
        end_clip($urandom_range(3, 20));
        begin_clip(NEXT_START, -1, 0);
        end_clip($urandom_range(3, 20));
        begin_clip(NEXT_START, -1, 0);
        chk("empty_after_3", empty, 1);
        end_clip($urandom_range(3, 20));
        wait_idle();

        // Fill to full during a clip, then push in the LOAD cycle while full
        push_one($urandom_range(0, 31));
        begin_clip(-1, -1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            push_one($urandom_range(0, 31));
            if (i == DEPTH - 2) chk("not_full_at_7", full, 0);
        end
        chk("full_at_8", full, 1);
        chk("no_overflow_at_8", overflow, 0);
        end_clip(5);
        begin_clip(NEXT_START, NEXT_START - 1, $urandom_range(0, 31));
        chk("full_after_swap", full, 1);
        chk("no_overflow_swap", overflow, 0);

        // A push while full with no pop is dropped and overflow sticks
        push_one($urandom_range(0, 31));
        chk("overflow_set", overflow, exp_ovf);
        chk("full_after_drop", full, 1);
        end_clip($urandom_range(3, 12));
        for (int i = 0; i < DEPTH; i++) begin
            begin_clip(NEXT_START, -1, 0);
            end_clip($urandom_range(3, 12));
        end
        wait_idle();
        chk("overflow_sticky", overflow, 1);
        chk("empty_after_drain", empty, 1);
`ifdef CLIP_SEQ_STATS_EN
        chk("clips_played_2", clips_played, 16'(exp_played));
        chk("max_depth_full", max_depth, CNT_W'(DEPTH));
`endif

        // Flush during PLAY with 4 queued and a coincident push
        push_one($urandom_range(0, 31));
        begin_clip(-1, -1, 0);
        for (int i = 0; i < 4; i++) push_one($urandom_range(0, 31));
        chk("queued_before_flush", empty, 0);
        r       = $urandom_range(0, 31);
        flush   = 1'b1;
        push    = 1'b1;
        push_id = ID_W'(r);
        tick();
        flush = 1'b0;
        push  = 1'b0;
        exp_q.delete();
        chk("empty_after_flush", empty, 1);
        chk("busy_after_flush", busy, 1);
        end_clip(8);
        wait_idle();
        starts = 0;
        repeat (20) begin
            tick();
            if (play_start === 1'b1) starts++;
        end
        chk("no_start_after_flush", starts, 0);
        chk("idle_after_flush", busy, 0);
`ifdef CLIP_SEQ_STATS_EN
        chk("max_depth_kept", max_depth, CNT_W'(DEPTH));
`endif

        // Reset while in START drops play_start and busy at once
        push_one($urandom_range(0, 31));
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (play_start === 1'b1) seen = 1'b1;
            else tick();
        end
        chk("start_before_reset", seen, 1);
        reset = 1'b1;
        #1;
        chk("async_play_start", play_start, 0);
        chk("async_busy", busy, 0);
        chk("async_addr", {start_address, end_address}, 48'h0);
`ifdef CLIP_SEQ_STATS_EN
        chk("async_clips_played", clips_played, 0);
`endif
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        chk("empty_after_reset", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
